mult_mode_cfg_sequencer: RTL and testbench

MULT_MODE_CFG_SEQUENCER -- requirements
Module: mult_mode_cfg_sequencer

---
 rtl/mult_mode_cfg_pkg.sv | 29 ++
 rtl/mult_mode_cfg_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mult_mode_cfg_sequencer.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_mode_cfg_pkg.sv
// ---------------------------------------------------------------------------
// mult_mode_cfg_pkg
//
// Shared definitions for the multiplier-mode configuration chain sequencer:
//   - state_t                     : sequencer FSM states
//   - CHAIN_BITS_DEFAULT          : length of the 6-bit multiplier-mode chain
//   - *_BIT / *_LSB / *_MSB       : bit positions of each field inside the
//                                   6-bit chain image
//                                   {IS_RSTMULTMODE_INVERTED,
//                                    IS_MULTMODE_INVERTED[3:0],
//                                    MULTMODEREG}
// ---------------------------------------------------------------------------
package mult_mode_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        VERIFY = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int CHAIN_BITS_DEFAULT = 6;

    localparam int MULTMODEREG_BIT              = 0;
    localparam int IS_MULTMODE_INVERTED_LSB     = 1;
    localparam int IS_MULTMODE_INVERTED_MSB     = 4;
    localparam int IS_RSTMULTMODE_INVERTED_BIT  = 5;

endpackage : mult_mode_cfg_pkg

// File: rtl/mult_mode_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// mult_mode_cfg_sequencer
//
// Serially loads a CHAIN_BITS-wide configuration image into a shift-register
// configuration chain, MSB first, and optionally reads it back to verify it.
//
// Optional feature (compile-time macro):
//   MULT_MODE_CFG_READBACK_EN - adds the VERIFY phase: the captured word is
//                               shifted through the chain a second time and
//                               the chain tail is compared bit by bit with the
//                               data being shifted in. Without it, error is
//                               only ever raised by abort.
//
// Ports:
//   clk                  in   rising-edge clock
//   rst_n                in   asynchronous active-low reset
//   start                in   load request, sampled only while idle
//   abort                in   synchronous cancel of a load/verify in progress
//   cfg_word             in   [CHAIN_BITS-1:0] image to load
//   configuration_input  out  registered serial data to the chain head
//   configuration_enable out  registered chain shift enable
//   cfg_chain_out        in   chain tail (last element's configuration_output)
//   busy                 out  high while loading or verifying
//   done                 out  one-cycle completion pulse
//   error                out  sticky failure flag, cleared by the next start
// ---------------------------------------------------------------------------
module mult_mode_cfg_sequencer
    import mult_mode_cfg_pkg::*;
#(
    parameter int CHAIN_BITS = CHAIN_BITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [CHAIN_BITS-1:0] cfg_word,
    output logic                  configuration_input,
    output logic                  configuration_enable,
    input  logic                  cfg_chain_out,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int              CW        = $clog2(CHAIN_BITS + 1);
    localparam logic [CW-1:0]   PHASE_LEN = CW'(CHAIN_BITS);
`ifdef MULT_MODE_CFG_READBACK_EN
    localparam logic [CW-1:0]   LAST_BIT  = CW'(CHAIN_BITS - 1);
`endif

    state_t                  state, state_nxt;
    logic [CHAIN_BITS-1:0]   shift_q, shift_nxt;
    logic [CW-1:0]           cnt_q, cnt_nxt;
    logic                    cin_nxt;
    logic                    cen_nxt;
    logic                    error_nxt;

`ifdef MULT_MODE_CFG_READBACK_EN
    // The count is 1..CHAIN_BITS exactly in the VERIFY cycles that present a
    // readback bit. The cycle with count 0 still carries the last LOAD bit,
    // whose chain tail holds stale contents, so it is excluded.
    logic mismatch;
    assign mismatch = configuration_enable && (cnt_q != '0) &&
                      (cfg_chain_out != configuration_input);
`else
    logic chain_out_unused;
    assign chain_out_unused = cfg_chain_out;
`endif

    assign busy = (state == LOAD) || (state == VERIFY);
    assign done = (state == DONE);

    // State, shift register, counter, serial outputs and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            shift_q              <= '0;
            cnt_q                <= '0;
            configuration_input  <= 1'b0;
            configuration_enable <= 1'b0;
            error                <= 1'b0;
        end else begin
            state                <= state_nxt;
            shift_q              <= shift_nxt;
            cnt_q                <= cnt_nxt;
            configuration_input  <= cin_nxt;
            configuration_enable <= cen_nxt;
            error                <= error_nxt;
        end
    end

    // Next-state logic. Each shifting cycle emits the shift register MSB and
    // rotates it, so after a full phase the captured word is back in place
    // for the readback pass. With readback, LOAD hands over to VERIFY on the
    // edge that emits its last bit so the enable stays high for 2*CHAIN_BITS
    // consecutive cycles; a phase otherwise ends once the count reaches
    // CHAIN_BITS.
    always_comb begin
        state_nxt = state;
        shift_nxt = shift_q;
        cnt_nxt   = cnt_q;
        cin_nxt   = 1'b0;
        cen_nxt   = 1'b0;
        error_nxt = error;

        unique case (state)
            IDLE: begin
                if (start) begin
                    shift_nxt = cfg_word;
                    cnt_nxt   = '0;
                    error_nxt = 1'b0;
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                if (abort) begin
                    error_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_q == PHASE_LEN) begin
                    state_nxt = DONE;
                end else begin
                    cen_nxt   = 1'b1;
                    cin_nxt   = shift_q[CHAIN_BITS-1];
                    shift_nxt = {shift_q[CHAIN_BITS-2:0], shift_q[CHAIN_BITS-1]};
                    cnt_nxt   = cnt_q + 1'b1;
`ifdef MULT_MODE_CFG_READBACK_EN
                    if (cnt_q == LAST_BIT) begin
                        cnt_nxt   = '0;
                        state_nxt = VERIFY;
                    end
`endif
                end
            end

`ifdef MULT_MODE_CFG_READBACK_EN
            VERIFY: begin
                if (abort) begin
                    error_nxt = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    if (mismatch) begin
                        error_nxt = 1'b1;
                    end
                    if (cnt_q == PHASE_LEN) begin
                        state_nxt = DONE;
                    end else begin
                        cen_nxt   = 1'b1;
                        cin_nxt   = shift_q[CHAIN_BITS-1];
                        shift_nxt = {shift_q[CHAIN_BITS-2:0], shift_q[CHAIN_BITS-1]};
                        cnt_nxt   = cnt_q + 1'b1;
                    end
                end
            end
`endif

            DONE: begin
                state_nxt = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule : mult_mode_cfg_sequencer

// File: tb/tb_mult_mode_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mult_mode_cfg_sequencer
//
// Drives directed and random load requests into the sequencer, attached to a
// behavioural CHAIN_BITS-long configuration chain. Expected results for every
// completed load are queued when the request is issued; a monitor collects
// the serial stream and pops/compares on each done pulse.
// Follows MULT_MODE_CFG_READBACK_EN the same way the design does.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mult_mode_cfg_sequencer;
    import mult_mode_cfg_pkg::*;

    localparam int N       = CHAIN_BITS_DEFAULT;
`ifdef MULT_MODE_CFG_READBACK_EN
    localparam int RB      = 1;
`else
    localparam int RB      = 0;
`endif
    localparam int TIMEOUT = 200;

    logic         clk        = 1'b0;
    logic         rst_n      = 1'b0;
    logic         start      = 1'b0;
    logic         abort      = 1'b0;
    logic [N-1:0] cfg_word   = '0;
    logic         configuration_input;
    logic         configuration_enable;
    logic         cfg_chain_out;
    logic         busy;
    logic         done;
    logic         error;

    logic [N-1:0] chain      = '0;
    logic         force_zero = 1'b0;
    logic         sticky_err = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [63:0]  bits;
        int           n_en;
        int           n_busy;
        logic         err;
        logic [N-1:0] chain;
    } exp_t;

    exp_t sb[$];
    exp_t mon_exp;

    mult_mode_cfg_sequencer #(.CHAIN_BITS(N)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .start                (start),
        .abort                (abort),
        .cfg_word             (cfg_word),
        .configuration_input  (configuration_input),
        .configuration_enable (configuration_enable),
        .cfg_chain_out        (cfg_chain_out),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    always #5 clk = ~clk;

    // Behavioural chain: each enabled edge shifts the head bit in; the first
    // bit shifted in ends up at the tail.
    always @(posedge clk) begin
        if (configuration_enable) begin
            chain <= {chain[N-2:0], configuration_input};
        end
    end
    assign cfg_chain_out = force_zero ? 1'b0 : chain[N-1];

    task automatic checkOutput(input string name, input logic [63:0] act,
                               input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the stream is the word MSB-first, once per pass; a
    // readback pass with the tail stuck at 0 fails whenever any bit is 1.
    function automatic exp_t modelLoad(input logic [N-1:0] word, input logic f0);
        exp_t e;
        int passes = RB + 1;
        e.bits = '0;
        for (int p = 0; p < passes; p++)
            for (int i = N - 1; i >= 0; i--)
                e.bits = {e.bits[62:0], word[i]};
        e.n_en   = N * passes;
        e.n_busy = N * passes + 1;
        e.err    = (RB == 1) && f0 && (word != '0);
        e.chain  = word;
        return e;
    endfunction

    // Monitor: gathers the serial stream while busy, checks on done.
    initial begin : monitor
        logic [63:0] seen_bits;
        int seen_en;
        int seen_busy;
        seen_bits = '0;
        seen_en   = 0;
        seen_busy = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen_bits = '0; seen_en = 0; seen_busy = 0;
            end else if (done) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_exp = sb.pop_front();
                    checkOutput("stream_bits",  seen_bits, mon_exp.bits);
                    checkOutput("enable_count", 64'(seen_en), 64'(mon_exp.n_en));
                    checkOutput("latency",      64'(seen_busy), 64'(mon_exp.n_busy));
                    checkOutput("done_error",   64'(error), 64'(mon_exp.err));
                    checkOutput("chain_image",  64'(chain), 64'(mon_exp.chain));
                end
                seen_bits = '0; seen_en = 0; seen_busy = 0;
            end else if (busy) begin
                seen_busy++;
                if (configuration_enable) begin
                    seen_bits = {seen_bits[62:0], configuration_input};
                    seen_en++;
                end
            end else begin
                seen_bits = '0; seen_en = 0; seen_busy = 0;
            end
        end
    end

    task automatic waitDone();
        for (int i = 0; i < TIMEOUT; i++) begin
            @(negedge clk);
            if (done) return;
        end
        checkOutput("done_timeout", 64'd0, 64'd1);
    endtask

    // Issues one load from an idle negedge; abort_at > 0 cancels it at that
    // busy cycle. Returns at a negedge with the sequencer idle.
    task automatic applyStimulus(input logic [N-1:0] word, input logic f0,
                                 input int abort_at);
        exp_t e;
        e = modelLoad(word, f0);
        checkOutput("error_hold", 64'(error), 64'(sticky_err));
        start      = 1'b1;
        cfg_word   = word;
        force_zero = f0;
        if (abort_at == 0) sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        cfg_word = ~word;
        checkOutput("start_accept", 64'({busy, error}), 64'(2'b10));
        if (abort_at > 0) begin
            repeat (abort_at - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
            checkOutput("abort_outputs",
                        64'({configuration_enable, busy, done, error}),
                        64'(4'b0001));
            sticky_err = 1'b1;
        end else begin
            waitDone();
            sticky_err = e.err;
            @(negedge clk);
        end
    endtask

    // start held high across a whole load: the second word must only be
    // taken in the idle cycle after done.
    task automatic busyStart(input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t ea;
        exp_t eb;
        ea = modelLoad(a, 1'b0);
        eb = modelLoad(b, 1'b0);
        force_zero = 1'b0;
        start      = 1'b1;
        cfg_word   = a;
        sb.push_back(ea);
        sb.push_back(eb);
        @(posedge clk);
        @(negedge clk);
        cfg_word = b;
        waitDone();
        @(negedge clk);
        checkOutput("busy_start_idle", 64'(busy), 64'd0);
        @(negedge clk);
        checkOutput("busy_start_second", 64'(busy), 64'd1);
        start = 1'b0;
        waitDone();
        sticky_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic resetMidLoad(input logic [N-1:0] word);
        start    = 1'b1;
        cfg_word = word;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_load",
                    64'({configuration_input, configuration_enable, busy, done, error}),
                    64'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        sticky_err = 1'b0;
    endtask

    initial begin : stimulus
        int nb;
        int ab;
        logic [N-1:0] w;
        logic f0;

        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_outputs",
                    64'({configuration_input, configuration_enable, busy, done, error}),
                    64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(6'b101101, 1'b0, 0);
        checkOutput("field_rstmultmode_inv", 64'(chain[IS_RSTMULTMODE_INVERTED_BIT]), 64'd1);
        checkOutput("field_multmode_inv",
                    64'(chain[IS_MULTMODE_INVERTED_MSB:IS_MULTMODE_INVERTED_LSB]),
                    64'(4'b0110));
        checkOutput("field_multmodereg", 64'(chain[MULTMODEREG_BIT]), 64'd1);

        applyStimulus(6'b111111, 1'b1, 0);
        applyStimulus(6'b010101, 1'b0, 0);
        applyStimulus(6'b101101, 1'b0, 3);
        applyStimulus(6'b000110, 1'b0, 0);
        resetMidLoad(6'b110011);
        applyStimulus(6'b001110, 1'b0, 0);
        busyStart(6'b100110, 6'b011001);

        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("idle_abort", 64'({busy, done, error}), 64'({2'b00, sticky_err}));

        nb = N * (RB + 1) + 1;
        for (int t = 0; t < 30; t++) begin
            w  = N'($urandom);
            f0 = ($urandom_range(0, 3) == 0);
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, nb)) : 0;
            applyStimulus(w, f0, ab);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult_mode_cfg_sequencer
